// File: rtl/sram_window_reader.sv
// sram_window_reader: fetches the 3x3 neighbourhood around (cx,cy) from a
// single-port SRAM with registered address and 1-cycle read latency, one
// read per cycle. It zero-pads taps outside the image and packs the nine
// pixels into one window.
//
// Handshake: start is a request that is accepted only while the FSM is IDLE
// and is neither queued nor remembered otherwise. win_valid is a one-cycle
// pulse with no back-pressure, and win is only meaningful in that cycle.
module sram_window_reader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 128,
  parameter int XW     = 8,
  parameter int YW     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [XW-1:0]         cx,
  input  logic [YW-1:0]         cy,
  output logic                  busy,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win,
  output logic                  sram_en,
  output logic                  sram_wen,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_d,
  input  logic [DATA_W-1:0]     sram_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          k_q;
  logic [XW-1:0]       cx_q;
  logic [YW-1:0]       cy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                pend_q;
  logic [3:0]          idx_q;
  logic                pad_q;
  logic [9*DATA_W-1:0] win_q;
  logic                win_valid_q;

  logic signed [1:0]   dy;
  logic signed [1:0]   dx;
  logic signed [YW:0]  r_s;
  logic signed [XW:0]  c_s;
  logic                tap_pad;
  logic [ADDR_W-1:0]   tap_addr;
  logic                issue;

  // Tap geometry: row/column offsets of tap k in raster order.
  always_comb begin
    dy = 2'sd0;
    dx = 2'sd0;
    case (k_q)
      4'd0: begin dy = -2'sd1; dx = -2'sd1; end
      4'd1: begin dy = -2'sd1; dx =  2'sd0; end
      4'd2: begin dy = -2'sd1; dx =  2'sd1; end
      4'd3: begin dy =  2'sd0; dx = -2'sd1; end
      4'd4: begin dy =  2'sd0; dx =  2'sd0; end
      4'd5: begin dy =  2'sd0; dx =  2'sd1; end
      4'd6: begin dy =  2'sd1; dx = -2'sd1; end
      4'd7: begin dy =  2'sd1; dx =  2'sd0; end
      4'd8: begin dy =  2'sd1; dx =  2'sd1; end
      default: begin dy = 2'sd0; dx = 2'sd0; end
    endcase
  end

  // Signed tap coordinates one bit wider than cx/cy, padding test and address.
  always_comb begin
    r_s      = $signed({1'b0, cy_q}) + $signed({{(YW-1){dy[1]}}, dy});
    c_s      = $signed({1'b0, cx_q}) + $signed({{(XW-1){dx[1]}}, dx});
    tap_pad  = (r_s < 0) || (int'(r_s) >= IMG_H) ||
               (c_s < 0) || (int'(c_s) >= IMG_W);
    tap_addr = {r_s[YW-1:0], c_s[XW-1:0]};
    issue    = (state_q == ISSUE);
  end

  // SRAM request and status decode from registered state and tap counter;
  // a padded tap leaves the address at its last issued value.
  always_comb begin
    sram_en   = issue && !tap_pad;
    sram_addr = sram_en ? tap_addr : addr_q;
    sram_wen  = 1'b1;
    sram_d    = '0;
    busy      = (state_q != IDLE);
    win       = win_q;
    win_valid = win_valid_q;
  end

  // Fetch FSM: accept in IDLE, issue nine taps, one drain cycle for tap 8.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      cx_q        <= '0;
      cy_q        <= '0;
      addr_q      <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= 1'b0;
      if (sram_en) addr_q <= tap_addr;
      case (state_q)
        IDLE: begin
          if (start) begin
            cx_q    <= cx;
            cy_q    <= cy;
            k_q     <= 4'd0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          k_q <= k_q + 4'd1;
          if (k_q == 4'd8) state_q <= DRAIN;
        end
        DRAIN: begin
          state_q     <= IDLE;
          win_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture pipeline: the tag of each issue cycle lands its slot one cycle
  // later, when the SRAM data for that tap is on sram_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      idx_q  <= 4'd0;
      pad_q  <= 1'b0;
      win_q  <= '0;
    end else begin
      pend_q <= issue;
      idx_q  <= k_q;
      pad_q  <= tap_pad;
      if (pend_q) win_q[idx_q*DATA_W +: DATA_W] <= pad_q ? '0 : sram_q;
    end
  end

endmodule
